// File: rtl/inst_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_fifo
// Brief    : Circular instruction queue between fetch and decode/dispatch,
//            presenting the head entry pre-split into instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue_fifo #(
    parameter int DEPTH       = 8,
    parameter int PTR_BITS    = 3,
    parameter int MEMORY_SIZE = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    output logic                in_ready,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [11:0]         opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [15:0]         immediate,
    output logic [25:0]         address,
    output logic [31:0]         pc,
    output logic                pc_in_range,
    output logic [PTR_BITS:0]   count,
    output logic                full,
    output logic                empty
);

    localparam logic [PTR_BITS:0] c_full_count = (PTR_BITS+1)'(DEPTH);
    localparam logic [31:0]       c_pc_limit   = 32'(MEMORY_SIZE - 1);

    logic [31:0]         r_inst_mem  [DEPTH];
    logic [31:0]         r_pc_mem    [DEPTH];
    logic                r_range_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [PTR_BITS:0]   r_count;

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_inst;
    logic [5:0]  w_major;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // in_ready is purely registered: a pop while full never frees a slot this cycle
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_ready && out_valid;

    // Storage carries no reset; empty-state masking keeps the outputs defined
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_inst_mem[r_wr_ptr]  <= in_inst;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_range_mem[r_wr_ptr] <= (in_pc <= c_pc_limit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_inst      = 32'd0;
        pc          = 32'd0;
        pc_in_range = 1'b0;
        if (!empty) begin
            w_inst      = r_inst_mem[r_rd_ptr];
            pc          = r_pc_mem[r_rd_ptr];
            pc_in_range = r_range_mem[r_rd_ptr];
        end
    end

    // R-type (major opcode 0) folds the function field into the low bits
    assign w_major   = w_inst[31:26];
    assign opcode    = (w_major == 6'd0) ? {w_major, w_inst[5:0]} : {w_major, 6'd0};
    assign rs        = w_inst[25:21];
    assign rt        = w_inst[20:16];
    assign rd        = w_inst[15:11];
    assign shamt     = w_inst[10:6];
    assign immediate = w_inst[15:0];
    assign address   = w_inst[25:0];

endmodule
`default_nettype wire

// File: tb/tb_inst_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue_fifo
// Brief    : Directed, table-driven self-checking bench for inst_queue_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue_fifo;

    localparam int DEPTH       = 8;
    localparam int PTR_BITS    = 3;
    localparam int MEMORY_SIZE = 2048;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [31:0]         in_inst;
    logic [31:0]         in_pc;
    logic                in_ready;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [11:0]         opcode;
    logic [4:0]          rs, rt, rd, shamt;
    logic [15:0]         immediate;
    logic [25:0]         address;
    logic [31:0]         pc;
    logic                pc_in_range;
    logic [PTR_BITS:0]   count;
    logic                full;
    logic                empty;

    int n_checks = 0;
    int n_errors = 0;

    inst_queue_fifo #(
        .DEPTH       (DEPTH),
        .PTR_BITS    (PTR_BITS),
        .MEMORY_SIZE (MEMORY_SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .immediate   (immediate),
        .address     (address),
        .pc          (pc),
        .pc_in_range (pc_in_range),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc_i;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_count;
        logic [11:0] e_op;
        logic [4:0]  e_rs;
        logic [4:0]  e_rt;
        logic [4:0]  e_rd;
        logic [4:0]  e_sh;
        logic [15:0] e_imm;
        logic [25:0] e_addr;
        logic [31:0] e_pc;
        logic        e_rng;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic f, input logic r);
        in_valid  = v;
        in_inst   = ins;
        in_pc     = p;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_pc     = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".empty"},     32'(empty),     32'd1);
        chk({tag, ".full"},      32'(full),      32'd0);
        chk({tag, ".count"},     32'(count),     32'd0);
        chk({tag, ".opcode"},    32'(opcode),    32'd0);
        chk({tag, ".pc"},        pc,             32'd0);
        chk({tag, ".range"},     32'(pc_in_range), 32'd0);
    endtask

    initial begin
        // add, then lw at out-of-range PC, pops, empty pop, boundary PC, push+pop, flush
        vecs[0] = '{1'b1, 32'h00851020, 32'd4,    1'b0, 1'b0, 1'b1, 4'd1, 12'h020, 5'd4,  5'd5,  5'd2,  5'd0,  16'h1020, 26'h0851020, 32'd4,    1'b1};
        vecs[1] = '{1'b1, 32'h8C220010, 32'd2048, 1'b0, 1'b0, 1'b1, 4'd2, 12'h020, 5'd4,  5'd5,  5'd2,  5'd0,  16'h1020, 26'h0851020, 32'd4,    1'b1};
        vecs[2] = '{1'b0, 32'h0,        32'd0,    1'b0, 1'b1, 1'b1, 4'd1, 12'h8C0, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0010, 26'h0220010, 32'd2048, 1'b0};
        vecs[3] = '{1'b0, 32'h0,        32'd0,    1'b0, 1'b1, 1'b0, 4'd0, 12'h000, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'd0,    1'b0};
        vecs[4] = '{1'b0, 32'h0,        32'd0,    1'b0, 1'b1, 1'b0, 4'd0, 12'h000, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'd0,    1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'd2047, 1'b0, 1'b1, 1'b1, 4'd1, 12'hFC0, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'd2047, 1'b1};
        vecs[6] = '{1'b1, 32'h00000000, 32'd16,   1'b0, 1'b1, 1'b1, 4'd1, 12'h000, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'd16,   1'b1};
        vecs[7] = '{1'b1, 32'hDEADBEEF, 32'd5,    1'b1, 1'b1, 1'b0, 4'd0, 12'h000, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'd0,    1'b0};
        vecs[8] = '{1'b0, 32'h0,        32'd0,    1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'd0,    1'b0};

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b1;
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_reset_state("idle");

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].v, vecs[i].inst, vecs[i].pc_i, vecs[i].fl, vecs[i].rdy);
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid),   32'(vecs[i].e_valid));
            chk($sformatf("v%0d.count", i),     32'(count),       32'(vecs[i].e_count));
            chk($sformatf("v%0d.empty", i),     32'(empty),       32'(vecs[i].e_count == 4'd0));
            chk($sformatf("v%0d.full", i),      32'(full),        32'(vecs[i].e_count == 4'd8));
            chk($sformatf("v%0d.in_ready", i),  32'(in_ready),    32'(vecs[i].e_count != 4'd8));
            chk($sformatf("v%0d.opcode", i),    32'(opcode),      32'(vecs[i].e_op));
            chk($sformatf("v%0d.rs", i),        32'(rs),          32'(vecs[i].e_rs));
            chk($sformatf("v%0d.rt", i),        32'(rt),          32'(vecs[i].e_rt));
            chk($sformatf("v%0d.rd", i),        32'(rd),          32'(vecs[i].e_rd));
            chk($sformatf("v%0d.shamt", i),     32'(shamt),       32'(vecs[i].e_sh));
            chk($sformatf("v%0d.imm", i),       32'(immediate),   32'(vecs[i].e_imm));
            chk($sformatf("v%0d.addr", i),      32'(address),     32'(vecs[i].e_addr));
            chk($sformatf("v%0d.pc", i),        pc,               vecs[i].e_pc);
            chk($sformatf("v%0d.range", i),     32'(pc_in_range), 32'(vecs[i].e_rng));
        end

        // Fill to full, push held off, pop while full does not admit a push
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1000 + 32'(i), 32'(i), 1'b0, 1'b0);
        chk("fill.full",     32'(full),     32'd1);
        chk("fill.in_ready", 32'(in_ready), 32'd0);
        chk("fill.count",    32'(count),    32'd8);
        chk("fill.head",     pc,            32'd0);
        cyc(1'b1, 32'h99, 32'd99, 1'b0, 1'b0);
        chk("fullpush.count", 32'(count), 32'd8);
        chk("fullpush.head",  pc,         32'd0);
        cyc(1'b1, 32'h99, 32'd99, 1'b0, 1'b1);
        chk("fullpop.count", 32'(count), 32'd7);
        chk("fullpop.head",  pc,         32'd1);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain%0d.pc", i), pc, 32'(i));
            cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.count", 32'(count), 32'd0);

        // Pointer wrap under continuous push+pop at occupancy 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'd0, 32'd100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'd0, 32'd103 + 32'(i), 1'b0, 1'b1);
            chk($sformatf("wrap%0d.pc", i),    pc,           32'd101 + 32'(i));
            chk($sformatf("wrap%0d.count", i), 32'(count),   32'd3);
        end

        // Flush at count 5 with a push and pop pending
        cyc(1'b1, 32'd0, 32'd200, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, 32'd201, 1'b0, 1'b0);
        chk("preflush.count", 32'(count), 32'd5);
        cyc(1'b1, 32'h00851020, 32'd555, 1'b1, 1'b1);
        chk("flush.count",     32'(count),     32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("postflush.count", 32'(count), 32'd0);
        chk("postflush.pc",    pc,         32'd0);

        // Asynchronous reset between edges at count 4
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'd0, 32'd300 + 32'(i), 1'b0, 1'b0);
        idle_inputs();
        chk("prerst.count", 32'(count), 32'd4);
        #2 rst = 1'b0;
        #1;
        chk_reset_state("async");
        #2 rst = 1'b1;
        cyc(1'b1, 32'd0, 32'd12, 1'b0, 1'b0);
        chk("postrst.pc",    pc,         32'd12);
        chk("postrst.count", 32'(count), 32'd1);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_queue_fifo.md
Name: inst_queue_fifo

Overview:
Parametrised instruction queue sitting between instruction memory fetch and the decode/dispatch stage of the out-of-order core. It buffers up to DEPTH fetched instructions with their PCs in a circular FIFO. It presents the head entry pre-split into opcode/rs/rt/rd/shamt/immediate/address fields. It supports valid/ready handshakes on both sides, a pipeline flush for branch mispredict, and per-entry PC range checking.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
PTR_BITS, 3, log2(DEPTH); width of the read and write pointers
MEMORY_SIZE, 2048, instruction memory words; an entry's PC is in range iff PC <= MEMORY_SIZE-1 (unsigned)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents an instruction this cycle
in_inst  in  32  raw instruction word
in_pc  in  32  PC of in_inst
in_ready  out  1  queue accepts a push this cycle; equals !full
flush  in  1  synchronous discard of all entries (branch mispredict)
out_ready  in  1  dispatch consumes the head this cycle
out_valid  out  1  head entry is valid; equals !empty
opcode  out  12  {inst[31:26], inst[5:0]} if inst[31:26]==0, otherwise {inst[31:26], 6'd0}
rs, rt, rd, shamt  out  5 each  inst[25:21], inst[20:16], inst[15:11], inst[10:6]
immediate  out  16  inst[15:0]
address  out  26  inst[25:0]
pc  out  32  PC of the head entry
pc_in_range  out  1  head PC <= MEMORY_SIZE-1
count  out  PTR_BITS+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Storage: DEPTH x (32-bit inst + 32-bit pc + 1-bit range flag). The range flag is computed at push time from in_pc.
- Pointers: wr_ptr and rd_ptr are PTR_BITS wide and wrap naturally from DEPTH-1 to 0. count is kept as a separate register; full and empty are derived from count only.
- push = in_valid && in_ready. pop = out_ready && out_valid.
- Each rising edge, in priority order:
  1. flush=1: wr_ptr=rd_ptr=0 and count=0. Any push or pop in the same cycle is ignored, so the pushed instruction is dropped.
  2. push && pop: write at wr_ptr, both pointers advance, count unchanged. This is legal at any non-empty, non-full occupancy.
  3. push only: write at wr_ptr, wr_ptr+1, count+1.
  4. pop only: rd_ptr+1, count-1.
- Push when full cannot occur because in_ready=0; in_valid while full is held off by fetch and the queue state is unchanged.
- Pop when empty is ignored; out_ready while empty has no effect.
- No same-cycle bypass: an instruction pushed in cycle N appears at the head no earlier than cycle N+1. Push-to-out_valid latency is 1 cycle.
- in_ready depends only on registered state and has no combinational path from out_ready. When full, a simultaneous pop does not enable a push in the same cycle.
- Head outputs are combinational decodes of the storage at rd_ptr. When empty, all field outputs, pc and pc_in_range are forced to 0.
- Asynchronous reset (rst=0): pointers=0, count=0, storage contents don't-care.
  - Outputs during and after reset: out_valid=0, empty=1, full=0, in_ready=1, count=0, all fields/pc/pc_in_range=0.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- No X propagation: the empty-state output masking guarantees defined outputs after reset.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, empty=1, count=0, opcode=0, pc=0.
- Push inst 0x00851020 (add) pc=4 -> next cycle: out_valid=1, opcode=12'h020, rs=4, rt=5, rd=2, shamt=0, pc=4, pc_in_range=1, count=1. Push 0x8C220010 (lw) pc=2048 -> after the first is popped: opcode=12'h8C0, immediate=16'h0010, pc_in_range=0.
- Fill with pcs 0..7, out_ready=0 -> full=1, in_ready=0, count=8. Assert in_valid with pc=99 -> count stays 8. Pop all -> pcs 0..7 come out in order, then empty=1.
- Pointer wrap: with count=3, run 20 cycles of simultaneous push/pop -> count stays 3 and output pc sequence is strictly in push order across the wrap.
- Flush with count=5 while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the flushed-cycle instruction is absent.
- Drive rst low between clock edges with count=4 -> outputs go to reset values immediately. Release rst, push pc=12 -> the head shows pc=12.
